// File: rtl/alu_share_arbiter_pkg.sv
// Shared definitions for the two-requester ALU arbiter: default widths,
// ALU opcode encodings and the round-robin grant helper.
package alu_share_arbiter_pkg;

  localparam int DEF_DATA_WIDTH  = 32;
  localparam int DEF_OP_WIDTH    = 4;
  localparam int DEF_SHAMT_WIDTH = 5;
  localparam int NUM_REQ         = 2;

  // ALU operation encodings; any other code yields result 0 / zero 1.
  localparam logic [3:0] ALU_AND = 4'd0;
  localparam logic [3:0] ALU_OR  = 4'd1;
  localparam logic [3:0] ALU_NOR = 4'd2;
  localparam logic [3:0] ALU_ADD = 4'd3;
  localparam logic [3:0] ALU_SUB = 4'd4;
  localparam logic [3:0] ALU_SLL = 4'd5;

  // One-hot grant: a lone requester always wins; on contention the requester
  // that did not win last time gets the slot.
  function automatic logic [1:0] rr_grant(input logic [1:0] valid,
                                          input logic       rr_last);
    logic [1:0] g;
    g = 2'b00;
    case (valid)
      2'b01:   g = 2'b01;
      2'b10:   g = 2'b10;
      2'b11:   g = rr_last ? 2'b01 : 2'b10;
      default: g = 2'b00;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/alu_share_arbiter_if.sv
// Request/response bundle between the requesters/consumer and the arbiter.
interface alu_share_arbiter_if
  import alu_share_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int OP_WIDTH    = DEF_OP_WIDTH,
  parameter int SHAMT_WIDTH = DEF_SHAMT_WIDTH
);

  // Handshake rules: a transfer happens on a rising clock edge where valid
  // and ready are both high. A requester keeps valid and its op/operands
  // stable until it sees ready; ready may depend on valid. The response side
  // holds resp_id/resp_result/resp_zero stable while resp_valid is high and
  // resp_ready is low.
  logic [NUM_REQ-1:0]             req_valid;
  logic [NUM_REQ-1:0]             req_ready;
  logic [NUM_REQ*OP_WIDTH-1:0]    req_op;
  logic [NUM_REQ*DATA_WIDTH-1:0]  req_a;
  logic [NUM_REQ*DATA_WIDTH-1:0]  req_b;
  logic [NUM_REQ*SHAMT_WIDTH-1:0] req_shamt;
  logic                           resp_valid;
  logic                           resp_ready;
  logic                           resp_id;
  logic [DATA_WIDTH-1:0]          resp_result;
  logic                           resp_zero;

  // Requesters and result consumer.
  modport master (
    output req_valid, req_op, req_a, req_b, req_shamt, resp_ready,
    input  req_ready, resp_valid, resp_id, resp_result, resp_zero
  );

  // The arbiter.
  modport slave (
    input  req_valid, req_op, req_a, req_b, req_shamt, resp_ready,
    output req_ready, resp_valid, resp_id, resp_result, resp_zero
  );

endinterface

// File: rtl/alu_share_arbiter_alu.sv
// Combinational ALU: AND/OR/NOR/ADD/SUB/SLL with a zero flag. Sums wrap,
// SLL shifts A by shamt and ignores B, unknown opcodes return 0.
module alu_share_arbiter_alu
  import alu_share_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int OP_WIDTH    = DEF_OP_WIDTH,
  parameter int SHAMT_WIDTH = DEF_SHAMT_WIDTH
) (
  input  logic [OP_WIDTH-1:0]    op_i,
  input  logic [DATA_WIDTH-1:0]  a_i,
  input  logic [DATA_WIDTH-1:0]  b_i,
  input  logic [SHAMT_WIDTH-1:0] shamt_i,
  output logic [DATA_WIDTH-1:0]  result_o,
  output logic                   zero_o
);

  // Operation select; default covers every unlisted opcode.
  always_comb begin
    result_o = '0;
    case (op_i)
      OP_WIDTH'(ALU_AND): result_o = a_i & b_i;
      OP_WIDTH'(ALU_OR):  result_o = a_i | b_i;
      OP_WIDTH'(ALU_NOR): result_o = ~(a_i | b_i);
      OP_WIDTH'(ALU_ADD): result_o = a_i + b_i;
      OP_WIDTH'(ALU_SUB): result_o = a_i - b_i;
      OP_WIDTH'(ALU_SLL): result_o = a_i << shamt_i;
      default:            result_o = '0;
    endcase
  end

  assign zero_o = (result_o == '0);

endmodule

// File: rtl/alu_share_arbiter.sv
// Two requesters share one ALU through a round-robin arbiter and a two-stage
// pipeline (issue register -> result register) with one tagged response port.
module alu_share_arbiter
  import alu_share_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int OP_WIDTH    = DEF_OP_WIDTH,
  parameter int SHAMT_WIDTH = DEF_SHAMT_WIDTH
) (
  input  logic                clk,
  input  logic                reset,
  alu_share_arbiter_if.slave  bus
);

  // Issue stage (drives the ALU).
  logic                   issue_valid_q, issue_valid_d;
  logic [OP_WIDTH-1:0]    issue_op_q;
  logic [DATA_WIDTH-1:0]  issue_a_q;
  logic [DATA_WIDTH-1:0]  issue_b_q;
  logic [SHAMT_WIDTH-1:0] issue_shamt_q;
  logic                   issue_id_q;

  // Result stage (drives the response port).
  logic                   resp_valid_q, resp_valid_d;
  logic                   resp_id_q;
  logic [DATA_WIDTH-1:0]  resp_result_q;
  logic                   resp_zero_q;

  // Index of the requester accepted most recently; 1 after reset so that
  // requester 0 wins the first contention.
  logic                   rr_last_q, rr_last_d;

  logic [1:0]             grant;
  logic                   adv_out;
  logic                   can_accept;
  logic                   accept;
  logic                   acc_id;

  logic [OP_WIDTH-1:0]    sel_op;
  logic [DATA_WIDTH-1:0]  sel_a;
  logic [DATA_WIDTH-1:0]  sel_b;
  logic [SHAMT_WIDTH-1:0] sel_shamt;

  logic [DATA_WIDTH-1:0]  alu_result;
  logic                   alu_zero;

  // The issue entry moves forward when the result register is empty or is
  // being drained this cycle; the issue register takes a new op when it is
  // empty or moving forward, so a stalled consumer backs up both stages.
  assign adv_out    = issue_valid_q & (~resp_valid_q | bus.resp_ready);
  assign can_accept = ~issue_valid_q | adv_out;

  assign grant         = rr_grant(bus.req_valid, rr_last_q);
  // Gate with reset so nothing is offered while the block is held in reset.
  assign bus.req_ready = reset ? (grant & {2{can_accept}}) : 2'b00;
  assign accept        = |(bus.req_valid & bus.req_ready);
  assign acc_id        = bus.req_ready[1];

  // Operand mux for the granted requester.
  assign sel_op    = acc_id ? bus.req_op[OP_WIDTH +: OP_WIDTH]
                            : bus.req_op[0 +: OP_WIDTH];
  assign sel_a     = acc_id ? bus.req_a[DATA_WIDTH +: DATA_WIDTH]
                            : bus.req_a[0 +: DATA_WIDTH];
  assign sel_b     = acc_id ? bus.req_b[DATA_WIDTH +: DATA_WIDTH]
                            : bus.req_b[0 +: DATA_WIDTH];
  assign sel_shamt = acc_id ? bus.req_shamt[SHAMT_WIDTH +: SHAMT_WIDTH]
                            : bus.req_shamt[0 +: SHAMT_WIDTH];

  // Next-state for the stage valid bits and the round-robin pointer. A load
  // into a stage wins over its drain, so streaming leaves no bubble.
  always_comb begin
    issue_valid_d = issue_valid_q;
    if (accept) begin
      issue_valid_d = 1'b1;
    end else if (adv_out) begin
      issue_valid_d = 1'b0;
    end

    resp_valid_d = resp_valid_q;
    if (adv_out) begin
      resp_valid_d = 1'b1;
    end else if (resp_valid_q & bus.resp_ready) begin
      resp_valid_d = 1'b0;
    end

    rr_last_d = accept ? acc_id : rr_last_q;
  end

  // Control state: stage valid bits and round-robin pointer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      issue_valid_q <= 1'b0;
      resp_valid_q  <= 1'b0;
      rr_last_q     <= 1'b1;
    end else begin
      issue_valid_q <= issue_valid_d;
      resp_valid_q  <= resp_valid_d;
      rr_last_q     <= rr_last_d;
    end
  end

  // Issue register payload, captured on accept and held otherwise.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      issue_op_q    <= '0;
      issue_a_q     <= '0;
      issue_b_q     <= '0;
      issue_shamt_q <= '0;
      issue_id_q    <= 1'b0;
    end else if (accept) begin
      issue_op_q    <= sel_op;
      issue_a_q     <= sel_a;
      issue_b_q     <= sel_b;
      issue_shamt_q <= sel_shamt;
      issue_id_q    <= acc_id;
    end
  end

  alu_share_arbiter_alu #(
    .DATA_WIDTH  (DATA_WIDTH),
    .OP_WIDTH    (OP_WIDTH),
    .SHAMT_WIDTH (SHAMT_WIDTH)
  ) u_alu (
    .op_i     (issue_op_q),
    .a_i      (issue_a_q),
    .b_i      (issue_b_q),
    .shamt_i  (issue_shamt_q),
    .result_o (alu_result),
    .zero_o   (alu_zero)
  );

  // Result register payload, captured when the issue entry advances.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      resp_id_q     <= 1'b0;
      resp_result_q <= '0;
      resp_zero_q   <= 1'b0;
    end else if (adv_out) begin
      resp_id_q     <= issue_id_q;
      resp_result_q <= alu_result;
      resp_zero_q   <= alu_zero;
    end
  end

  assign bus.resp_valid  = resp_valid_q;
  assign bus.resp_id     = resp_id_q;
  assign bus.resp_result = resp_result_q;
  assign bus.resp_zero   = resp_zero_q;

endmodule
